// File: rtl/edge_level_generator.sv
// edge_level_generator: turns rise/fall request pulses into a registered level with minimum high/low hold times
module edge_level_generator #(
  parameter int MIN_HIGH = 4,
  parameter int MIN_LOW  = 4,
  parameter int HOLD_W   = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rise_req,
  input  logic             fall_req,
  output logic             level,
  output logic             busy,
  output logic             rise_done,
  output logic             fall_done,
  output logic             drop,
  output logic [CNT_W-1:0] edge_count
);
  typedef enum logic [1:0] {LOW, HOLD_HI, HIGH, HOLD_LO} state_t;
  localparam logic [HOLD_W-1:0] HI_LOAD = HOLD_W'(MIN_HIGH - 1);
  localparam logic [HOLD_W-1:0] LO_LOAD = HOLD_W'(MIN_LOW - 1);
  state_t state, state_n;
  logic [HOLD_W-1:0] cnt, cnt_n;
  logic pend, pend_n, rd_n, fd_n, drop_n, r, f;
  assign r = rise_req & ~fall_req;
  assign f = fall_req & ~rise_req;
  // next state: simultaneous requests cancel each other and only raise drop; hold timer keeps running
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pend_n  = pend;
    rd_n    = 1'b0;
    fd_n    = 1'b0;
    drop_n  = rise_req & fall_req;
    case (state)
      LOW: if (r) begin
        state_n = HOLD_HI;
        cnt_n   = HI_LOAD;
        rd_n    = 1'b1;
      end
      HIGH: if (f) begin
        state_n = HOLD_LO;
        cnt_n   = LO_LOAD;
        fd_n    = 1'b1;
      end
      HOLD_HI: if (cnt != '0) begin
        cnt_n  = cnt - 1'b1;
        pend_n = f ? 1'b1 : r ? 1'b0 : pend;
        drop_n = drop_n | (f & pend);
      end else if (pend | f) begin
        state_n = HOLD_LO;
        cnt_n   = LO_LOAD;
        pend_n  = 1'b0;
        fd_n    = 1'b1;
      end else begin
        state_n = HIGH;
        pend_n  = 1'b0;
      end
      HOLD_LO: if (cnt != '0) begin
        cnt_n  = cnt - 1'b1;
        pend_n = r ? 1'b1 : f ? 1'b0 : pend;
        drop_n = drop_n | (r & pend);
      end else if (pend | r) begin
        state_n = HOLD_HI;
        cnt_n   = HI_LOAD;
        pend_n  = 1'b0;
        rd_n    = 1'b1;
      end else begin
        state_n = LOW;
        pend_n  = 1'b0;
      end
      default: state_n = LOW;
    endcase
  end
  // state, counter and every output are registered from the next-state decode
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= LOW;
      cnt        <= '0;
      pend       <= 1'b0;
      level      <= 1'b0;
      busy       <= 1'b0;
      rise_done  <= 1'b0;
      fall_done  <= 1'b0;
      drop       <= 1'b0;
      edge_count <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      pend       <= pend_n;
      level      <= (state_n == HOLD_HI) || (state_n == HIGH);
      busy       <= (state_n == HOLD_HI) || (state_n == HOLD_LO);
      rise_done  <= rd_n;
      fall_done  <= fd_n;
      drop       <= drop_n;
      edge_count <= edge_count + CNT_W'(rd_n | fd_n);
    end
  end
endmodule

// File: doc/edge_level_generator.md
# edge_level_generator

Command-driven level generator: the transmit-side counterpart of the dual-edge detector. Single-cycle rise/fall request pulses from control logic are converted into a clean registered level with guaranteed minimum high and low times, so that every edge is visible to a downstream edge detector. The block emits one-cycle completion ticks and a running edge count. A one-deep pending request absorbs commands that arrive while a hold time is running.

## Interface
- `MIN_HIGH`, default 4: minimum cycles `level` stays 1 after a rising edge; legal range 1 to 2^`HOLD_W`.
- `MIN_LOW`, default 4: minimum cycles `level` stays 0 after a falling edge; legal range 1 to 2^`HOLD_W`.
- `HOLD_W`, default 8: width of the hold counter.
- `CNT_W`, default 16: width of `edge_count`.
- `clk` input, 1 bit: single clock; all logic is on the rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `rise_req` input, 1 bit: request a rising edge; a one-cycle pulse, sampled every clock.
- `fall_req` input, 1 bit: request a falling edge; a one-cycle pulse, sampled every clock.
- `level` output, 1 bit: generated level, registered and glitch-free.
- `busy` output, 1 bit: a hold time is running.
- `rise_done` output, 1 bit: one-cycle tick on the first cycle that `level` is 1.
- `fall_done` output, 1 bit: one-cycle tick on the first cycle that `level` is 0 after being 1.
- `drop` output, 1 bit: one-cycle tick when a request is discarded.
- `edge_count` output, `CNT_W` bits: number of edges produced; wraps.

## Operation
- FSM states:
  - LOW: `level`=0, `busy`=0.
  - HOLD_HI: `level`=1, `busy`=1.
  - HIGH: `level`=1, `busy`=0.
  - HOLD_LO: `level`=0, `busy`=1.
- Unused state encodings go to LOW.
- All outputs are registered. Reset state: LOW, `level`=0, `busy`=0, all ticks 0, `edge_count`=0, `pend`=0, hold counter = 0.
- Simultaneous `rise_req` and `fall_req` in any state: both are discarded, `drop`=1 for one cycle, no state change, `pend` unchanged.
- LOW:
  - `rise_req` → HOLD_HI, load counter with `MIN_HIGH`-1.
  - `fall_req` is a no-op and does not assert `drop`.
- HIGH:
  - `fall_req` → HOLD_LO, load counter with `MIN_LOW`-1.
  - `rise_req` is a no-op.
- HOLD_HI, counter nonzero: decrement the counter.
  - `fall_req` sets `pend`.
  - `rise_req` clears `pend` (net request cancelled).
  - If `pend` was already set, a second `fall_req` asserts `drop` and leaves `pend` at 1.
- HOLD_HI, counter zero:
  - If `pend`=1 or `fall_req`=1: go to HOLD_LO, load counter with `MIN_LOW`-1, clear `pend`.
  - Otherwise go to HIGH and clear `pend`.
- HOLD_LO is symmetric to HOLD_HI, with `rise_req` as the opposite request and HOLD_HI / LOW as the successors.
- `rise_done` is asserted with the first HOLD_HI cycle. `fall_done` is asserted with the first HOLD_LO cycle.
- `edge_count` increments by 1 on every `rise_done` and every `fall_done`. It is modulo 2^`CNT_W` and wraps from all-ones to 0 with no flag.

## Timing
- A request sampled at edge N changes `level` in cycle N+1; the matching done tick is asserted in the same cycle.
- `edge_count` reflects that edge from cycle N+1.
- After a rising edge, `level` is 1 for exactly `MIN_HIGH` cycles of HOLD_HI and then stays 1 in HIGH. Under a continuous alternating load the high time is exactly `MIN_HIGH`; the same holds for low and `MIN_LOW`.
- With `MIN_HIGH`=1, HOLD_HI lasts one cycle. A `fall_req` sampled in that cycle goes straight to HOLD_LO, so `level` is high for 1 cycle.
- `busy` rises with the edge (cycle N+1) and falls in the first HIGH or LOW cycle.
- Pending request executes on the clock at which the counter reads 0. The opposite edge appears one cycle after the last hold cycle, with no idle cycle in between.
- Asserting `reset_n` low mid-hold forces `level`=0 and `busy`=0 immediately and asynchronously.
  - No `fall_done` tick is produced and `pend` is lost.
  - After release, the first clock edge is treated as LOW.

## Test plan
- Reset, then `rise_req` at cycle 2 (`MIN_HIGH`=3) → `level`=1 in cycles 3-5 with `busy`=1, `busy`=0 from cycle 6, `rise_done` only at cycle 3, `edge_count`=1.
- `MIN_HIGH`=3, `MIN_LOW`=2: `rise_req` at cycle 2 and `fall_req` at cycle 3 → `pend` set, `level` falls at cycle 6, `level`=0 with `busy`=1 in cycles 6-7, LOW at cycle 8, `edge_count`=2.
- In HOLD_HI, `fall_req` then `rise_req` two cycles later → pending cancelled, FSM settles in HIGH, `edge_count`=1, no `drop`.
- `rise_req` and `fall_req` together in LOW → `drop`=1 for one cycle, `level` stays 0, count unchanged.
- Redundant requests: `rise_req` in HIGH and `fall_req` in LOW → no state change, no tick, no `drop`.
- `CNT_W`=4 with 16 alternating edges → `edge_count` wraps to 0. Reset pulse during HOLD_LO → all outputs 0 immediately, no `fall_done`.
